// File: rtl/div_by_five_pkg.sv
// Shared types and select encodings for the divide-by-five controller/datapath pair.
package div_by_five_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CALC   = 3'd1,
        FLUSH1 = 3'd2,
        FLUSH2 = 3'd3,
        DONE   = 3'd4
    } state_e;

    localparam logic IN_SEL_LOAD  = 1'b0;
    localparam logic IN_SEL_SHIFT = 1'b1;
    localparam logic ACC_SEL_CLR  = 1'b0;
    localparam logic ACC_SEL_ACC  = 1'b1;
    localparam logic C_SEL_ZERO   = 1'b0;
    localparam logic C_SEL_REG    = 1'b1;

endpackage

// File: rtl/div_by_five_ctrl.sv
// Controller for a nibble-serial divisible-by-five checker: sequences load, end-around
// accumulation, two carry flushes and a held result behind a valid/ready handshake.
module div_by_five_ctrl #(
    parameter int BIT_WIDTH = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic in_val,
    output logic in_rdy,
    output logic out_val,
    input  logic out_rdy,
    output logic result,
    input  logic all_z,
    input  logic dp_out_msg,
    output logic in_sel,
    output logic acc_sel,
    output logic c_sel
);
    import div_by_five_pkg::*;

    localparam int               CNT_W    = $clog2(BIT_WIDTH / 4 + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_WIDTH / 4 - 1);

    state_e           r_state;
    state_e           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_result;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_result <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE:    r_cnt    <= '0;
                CALC:    r_cnt    <= r_cnt + 1'b1;
                FLUSH2:  r_result <= dp_out_msg;
                default: ;
            endcase
        end
    end

    // NOTE: every output of this block gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next  = r_state;
        in_rdy  = 1'b0;
        out_val = 1'b0;
        in_sel  = IN_SEL_LOAD;
        acc_sel = ACC_SEL_CLR;
        c_sel   = C_SEL_ZERO;
        case (r_state)
            IDLE: begin
                in_rdy = 1'b1;
                if (in_val) w_next = CALC;
            end
            CALC: begin
                in_sel  = IN_SEL_SHIFT;
                acc_sel = ACC_SEL_ACC;
                // Stale carry from a previous or abandoned operation is masked on the first nibble.
                c_sel   = (r_cnt == '0) ? C_SEL_ZERO : C_SEL_REG;
                if (all_z || (r_cnt == CNT_LAST)) w_next = FLUSH1;
            end
            FLUSH1, FLUSH2: begin
                in_sel  = IN_SEL_SHIFT;
                acc_sel = ACC_SEL_ACC;
                c_sel   = C_SEL_REG;
                w_next  = (r_state == FLUSH1) ? FLUSH2 : DONE;
            end
            DONE: begin
                out_val = 1'b1;
                if (out_rdy) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign result = r_result;

endmodule
